// File: rtl/alu_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : alu_ex_stage
// Purpose  : EX stage - ALU, EX/MEM register, BNEQ/JUMP resolution with
//            single-slot wrong-path squash, stall and flush handling.
// Revision : 1.0
// ============================================================================
module alu_ex_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [5:0]       opcode,
    input  logic [3:0]       ALUControl,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic [WIDTH-1:0] store_data,
    input  logic [4:0]       dest_reg,
    input  logic             reg_write,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic [WIDTH-1:0] branch_target,
    input  logic             stall,
    input  logic             flush,
    output logic             exmem_valid,
    output logic [WIDTH-1:0] exmem_result,
    output logic             exmem_zero,
    output logic             exmem_overflow,
    output logic [WIDTH-1:0] exmem_store_data,
    output logic [4:0]       exmem_dest_reg,
    output logic             exmem_reg_write,
    output logic             exmem_mem_read,
    output logic             exmem_mem_write,
    output logic             redirect,
    output logic [WIDTH-1:0] redirect_pc,
    output logic             alu_err
);

    localparam logic [5:0] c_op_bneq = 6'b000101;
    localparam logic [5:0] c_op_jump = 6'b100000;
    localparam logic [3:0] c_alu_add = 4'b0000;
    localparam logic [3:0] c_alu_sub = 4'b0110;
    localparam logic [3:0] c_alu_or  = 4'b0001;
    localparam logic [3:0] c_alu_and = 4'b0010;
    localparam logic [3:0] c_alu_xor = 4'b1100;

    typedef enum logic [0:0] {
        S_RUN    = 1'b0,
        S_SHADOW = 1'b1
    } state_t;

    state_t r_state, w_state_next;

    logic [WIDTH-1:0] w_sum, w_diff, w_result;
    logic             w_ovf, w_undef, w_accept, w_taken;

    logic             r_valid, r_zero, r_ovf, r_reg_write, r_mem_read, r_mem_write;
    logic [WIDTH-1:0] r_result, r_store_data, r_redirect_pc;
    logic [4:0]       r_dest_reg;
    logic             r_redirect, r_alu_err;

    assign w_sum  = operand_a + operand_b;
    assign w_diff = operand_a - operand_b;

    always_comb begin
        w_result = '0;
        w_ovf    = 1'b0;
        w_undef  = 1'b0;
        case (ALUControl)
            c_alu_add: begin
                w_result = w_sum;
                w_ovf    = (operand_a[WIDTH-1] == operand_b[WIDTH-1]) &&
                           (w_sum[WIDTH-1] != operand_a[WIDTH-1]);
            end
            c_alu_sub: begin
                w_result = w_diff;
                w_ovf    = (operand_a[WIDTH-1] != operand_b[WIDTH-1]) &&
                           (w_diff[WIDTH-1] != operand_a[WIDTH-1]);
            end
            c_alu_or:  w_result = operand_a | operand_b;
            c_alu_and: w_result = operand_a & operand_b;
            c_alu_xor: w_result = operand_a ^ operand_b;
            default:   w_undef  = 1'b1;
        endcase
    end

    // SHADOW blocks acceptance so the wrong-path slot becomes a bubble
    assign w_accept = id_valid && !flush && !stall && (r_state == S_RUN);
    assign w_taken  = w_accept &&
                      (((opcode == c_op_bneq) && (w_result != '0)) || (opcode == c_op_jump));

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_RUN:    if (w_taken) w_state_next = S_SHADOW;
            S_SHADOW: if (!stall)  w_state_next = S_RUN;
            default:  w_state_next = S_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_RUN;
        else       r_state <= w_state_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid       <= 1'b0;
            r_result      <= '0;
            r_zero        <= 1'b0;
            r_ovf         <= 1'b0;
            r_store_data  <= '0;
            r_dest_reg    <= '0;
            r_reg_write   <= 1'b0;
            r_mem_read    <= 1'b0;
            r_mem_write   <= 1'b0;
            r_redirect    <= 1'b0;
            r_redirect_pc <= '0;
            r_alu_err     <= 1'b0;
        end else begin
            r_redirect <= w_taken;
            if (w_taken) r_redirect_pc <= branch_target;
            if (w_accept && w_undef) r_alu_err <= 1'b1;
            if (!stall) begin
                r_valid      <= w_accept;
                r_result     <= w_accept ? w_result : '0;
                r_zero       <= w_accept && (w_result == '0);
                r_ovf        <= w_accept && w_ovf;
                r_store_data <= w_accept ? store_data : '0;
                r_dest_reg   <= w_accept ? dest_reg : 5'd0;
                r_reg_write  <= w_accept && reg_write;
                r_mem_read   <= w_accept && mem_read;
                r_mem_write  <= w_accept && mem_write;
            end
        end
    end

    assign exmem_valid      = r_valid;
    assign exmem_result     = r_result;
    assign exmem_zero       = r_zero;
    assign exmem_overflow   = r_ovf;
    assign exmem_store_data = r_store_data;
    assign exmem_dest_reg   = r_dest_reg;
    assign exmem_reg_write  = r_reg_write;
    assign exmem_mem_read   = r_mem_read;
    assign exmem_mem_write  = r_mem_write;
    assign redirect         = r_redirect;
    assign redirect_pc      = r_redirect_pc;
    assign alu_err          = r_alu_err;

endmodule
`default_nettype wire

// File: tb/tb_alu_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_ex_stage
// Purpose  : Self-checking bench for alu_ex_stage against a behavioural model.
// Revision : 1.0
// ============================================================================
module tb_alu_ex_stage;

    logic        clk = 1'b0;
    logic        reset, id_valid, reg_write, mem_read, mem_write, stall, flush;
    logic [5:0]  opcode;
    logic [3:0]  ALUControl;
    logic [31:0] operand_a, operand_b, store_data, branch_target;
    logic [4:0]  dest_reg;

    logic        exmem_valid, exmem_zero, exmem_overflow;
    logic [31:0] exmem_result, exmem_store_data, redirect_pc;
    logic [4:0]  exmem_dest_reg;
    logic        exmem_reg_write, exmem_mem_read, exmem_mem_write, redirect, alu_err;

    alu_ex_stage #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .opcode(opcode),
        .ALUControl(ALUControl), .operand_a(operand_a), .operand_b(operand_b),
        .store_data(store_data), .dest_reg(dest_reg), .reg_write(reg_write),
        .mem_read(mem_read), .mem_write(mem_write), .branch_target(branch_target),
        .stall(stall), .flush(flush),
        .exmem_valid(exmem_valid), .exmem_result(exmem_result), .exmem_zero(exmem_zero),
        .exmem_overflow(exmem_overflow), .exmem_store_data(exmem_store_data),
        .exmem_dest_reg(exmem_dest_reg), .exmem_reg_write(exmem_reg_write),
        .exmem_mem_read(exmem_mem_read), .exmem_mem_write(exmem_mem_write),
        .redirect(redirect), .redirect_pc(redirect_pc), .alu_err(alu_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 0;

    // Model of what EX/MEM and the redirect outputs must hold
    logic        m_valid, m_zero, m_ovf, m_rw, m_mr, m_mw, m_redirect, m_err;
    logic [31:0] m_result, m_sd, m_pc;
    logic [4:0]  m_dest;
    bit          m_squash;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void alu_ref(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] r, output logic o, output logic undef);
        longint sa, sb, s;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r = 32'd0; o = 1'b0; undef = 1'b0;
        case (c)
            4'b0000: begin s = sa + sb; r = s[31:0]; o = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            4'b0110: begin s = sa - sb; r = s[31:0]; o = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            4'b0001: r = a | b;
            4'b0010: r = a & b;
            4'b1100: r = a ^ b;
            default: undef = 1'b1;
        endcase
    endfunction

    task automatic model_step();
        logic [31:0] r;
        logic o, u;
        if (reset) begin
            {m_valid, m_zero, m_ovf, m_rw, m_mr, m_mw, m_redirect, m_err} = '0;
            m_result = 0; m_sd = 0; m_pc = 0; m_dest = 0; m_squash = 0;
            return;
        end
        m_redirect = 1'b0;
        if (stall) return;
        if (m_squash || flush || !id_valid) begin
            m_squash = 0;
            {m_valid, m_zero, m_ovf, m_rw, m_mr, m_mw} = '0;
            m_result = 0; m_sd = 0; m_dest = 0;
            return;
        end
        alu_ref(ALUControl, operand_a, operand_b, r, o, u);
        m_valid = 1; m_result = r; m_zero = (r == 0); m_ovf = o;
        m_sd = store_data; m_dest = dest_reg; m_rw = reg_write; m_mr = mem_read; m_mw = mem_write;
        if (u) m_err = 1;
        if (opcode == 6'b100000 || (opcode == 6'b000101 && r != 0)) begin
            m_redirect = 1; m_pc = branch_target; m_squash = 1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic set_op(input logic v, input logic [5:0] op, input logic [3:0] c,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] tgt);
        id_valid = v; opcode = op; ALUControl = c; operand_a = a; operand_b = b; branch_target = tgt;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("valid",     exmem_valid,      m_valid);
            chk("result",    exmem_result,     m_result);
            chk("zero",      exmem_zero,       m_zero);
            chk("overflow",  exmem_overflow,   m_ovf);
            chk("store",     exmem_store_data, m_sd);
            chk("dest",      exmem_dest_reg,   m_dest);
            chk("reg_write", exmem_reg_write,  m_rw);
            chk("mem_read",  exmem_mem_read,   m_mr);
            chk("mem_write", exmem_mem_write,  m_mw);
            chk("redirect",  redirect,         m_redirect);
            chk("rpc",       redirect_pc,      m_pc);
            chk("alu_err",   alu_err,          m_err);
        end
    end

    initial begin
        reset = 1; stall = 0; flush = 0; reg_write = 0; mem_read = 0; mem_write = 0;
        store_data = 32'h1234; dest_reg = 5'd3;
        set_op(0, 6'd0, 4'b0000, 0, 0, 0);
        tick(); tick();
        chk_en = 1;
        chk("rst_valid", exmem_valid, 0);
        chk("rst_result", exmem_result, 0);
        chk("rst_err", alu_err, 0);
        chk("rst_rpc", redirect_pc, 0);

        reset = 0; reg_write = 1;
        set_op(1, 6'd0, 4'b0000, 32'h7FFFFFFF, 32'd1, 0); tick();
        chk("add_res", exmem_result, 32'h80000000);
        chk("add_ovf", exmem_overflow, 1);
        chk("add_valid", exmem_valid, 1);
        chk("add_redir", redirect, 0);

        set_op(1, 6'd0, 4'b0110, 32'd5, 32'd5, 0); tick();
        chk("sub_zero", exmem_zero, 1);
        set_op(1, 6'd0, 4'b1100, 32'hF0F0, 32'h0FF0, 0); tick();
        chk("xor_res", exmem_result, 32'hFF00);
        chk("xor_zero", exmem_zero, 0);

        reg_write = 0;
        set_op(1, 6'b000101, 4'b0110, 32'd3, 32'd4, 32'h40); tick();
        chk("bneq_redir", redirect, 1);
        chk("bneq_rpc", redirect_pc, 32'h40);
        reg_write = 1;
        set_op(1, 6'd0, 4'b0000, 32'd1, 32'd2, 0); tick();
        chk("squash_valid", exmem_valid, 0);
        chk("squash_rw", exmem_reg_write, 0);
        chk("pulse_end", redirect, 0);
        tick();
        chk("after_sq_res", exmem_result, 32'd3);
        chk("after_sq_valid", exmem_valid, 1);

        set_op(1, 6'b000101, 4'b0110, 32'd7, 32'd7, 32'h80); tick();
        chk("nt_redir", redirect, 0);
        set_op(1, 6'd0, 4'b0000, 32'd10, 32'd20, 0); tick();
        chk("nt_next", exmem_result, 32'd30);

        mem_read = 1; dest_reg = 5'd8;
        set_op(1, 6'b100011, 4'b0000, 32'h100, 32'd4, 0); tick();
        stall = 1; flush = 1; mem_read = 0;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) set_op(1, 6'b100000, 4'b0000, 32'd9, 32'd9, 32'h200);
            else        set_op(1, 6'd0, 4'b0001, $urandom, $urandom, 0);
            tick();
            chk("stall_res", exmem_result, 32'h104);
            chk("stall_mr", exmem_mem_read, 1);
            chk("stall_redir", redirect, 0);
        end
        stall = 0; flush = 0; tick();
        chk("jump_redir", redirect, 1);
        chk("jump_rpc", redirect_pc, 32'h200);
        set_op(1, 6'd0, 4'b0000, 32'd1, 32'd1, 0); tick();
        chk("jump_sq", exmem_valid, 0);

        set_op(1, 6'd0, 4'b1111, 32'd5, 32'd6, 0); tick();
        chk("undef_res", exmem_result, 0);
        chk("undef_err", alu_err, 1);
        set_op(1, 6'd0, 4'b0000, 32'd5, 32'd6, 0); tick();
        chk("err_sticky", alu_err, 1);

        set_op(1, 6'b100000, 4'b0000, 0, 0, 32'h300); tick();
        reset = 1; tick();
        chk("shrst_valid", exmem_valid, 0);
        chk("shrst_err", alu_err, 0);
        reset = 0;
        set_op(1, 6'd0, 4'b0000, 32'd2, 32'd3, 0); tick();
        chk("shrst_cap", exmem_result, 32'd5);

        for (int i = 0; i < 600; i++) begin
            logic [3:0] codes [6];
            int r;
            codes[0] = 4'b0000; codes[1] = 4'b0110; codes[2] = 4'b0001;
            codes[3] = 4'b0010; codes[4] = 4'b1100; codes[5] = 4'($urandom);
            reset = ($urandom_range(0, 99) < 2);
            stall = ($urandom_range(0, 99) < 25);
            flush = ($urandom_range(0, 99) < 15);
            reg_write = 1'($urandom); mem_read = 1'($urandom); mem_write = 1'($urandom);
            store_data = $urandom; dest_reg = 5'($urandom);
            r = $urandom_range(0, 99);
            set_op($urandom_range(0, 99) < 80,
                   (r < 30) ? 6'b000101 : (r < 45) ? 6'b100000 : 6'($urandom),
                   codes[$urandom_range(0, 5)],
                   $urandom, $urandom, $urandom);
            if ($urandom_range(0, 3) == 0) operand_b = operand_a;
            if ($urandom_range(0, 3) == 0) operand_a = {1'b0, 31'($urandom)} | 32'h7FFF0000;
            tick();
        end

        @(negedge clk);
        chk_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
